// File: rtl/hps_reset_req_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hps_reset_req_sequencer_pkg                                    |
// | Brief    : FSM state encoding and pulse-length helper for the sequencer  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package hps_reset_req_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam int c_MIN_SYNC_STAGES = 2;

  // Cycle count N maps to a down-counter preload of N-1; a length of 0 still gives one cycle.
  function automatic int unsigned len_to_init(input int unsigned len);
    return (len == 0) ? 0 : len - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hps_reset_req_sequencer_edge_sync_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hps_reset_req_sequencer_edge_sync_detect                       |
// | Brief    : One channel: async level synchroniser, prev reg, edge detect  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module hps_reset_req_sequencer_edge_sync_detect
  import hps_reset_req_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_RISING = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_edge
);

  localparam int c_STAGES = (SYNC_STAGES < c_MIN_SYNC_STAGES) ? c_MIN_SYNC_STAGES : SYNC_STAGES;

  logic [c_STAGES-1:0] r_sync;
  logic                r_prev;
  logic                w_sync;

  assign w_sync = r_sync[c_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[c_STAGES-2:0], i_sig};
      r_prev <= w_sync;
    end
  end

  assign o_edge = (w_sync != r_prev) && (w_sync == EDGE_RISING);

endmodule
`default_nettype wire

// File: rtl/hps_reset_req_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hps_reset_req_sequencer                                        |
// | Brief    : Serialises HPS reset requests into stretched one-hot pulses   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module hps_reset_req_sequencer
  import hps_reset_req_sequencer_pkg::*;
#(
  parameter int                        NUM_CH                = 3,
  parameter int                        CNT_W                 = 8,
  // Fields listed channel 0 first, so channel 0 occupies the most significant field.
  parameter logic [NUM_CH*CNT_W-1:0]   PULSE_EXT_VEC         = {8'd32, 8'd2, 8'd6},
  parameter logic [NUM_CH-1:0]         EDGE_TYPE_VEC         = 3'b111,
  parameter int                        SYNC_STAGES           = 2,
  parameter int                        HOLDOFF               = 4,
  parameter bit                        IGNORE_RST_WHILE_BUSY = 1'b1,
  localparam int                       AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sys_rst_n,
  input  logic [NUM_CH-1:0] i_sig_in,
  input  logic              i_drop_clr,
  output logic [NUM_CH-1:0] o_pulse_out,
  output logic              o_busy,
  output logic [AW-1:0]     o_active_ch,
  output logic [NUM_CH-1:0] o_pending,
  output logic              o_drop_sticky
);

  localparam int               c_ARM       = ((SYNC_STAGES < c_MIN_SYNC_STAGES) ? c_MIN_SYNC_STAGES : SYNC_STAGES) + 1;
  localparam logic [CNT_W-1:0] c_HOLD_INIT = CNT_W'(len_to_init(HOLDOFF));

  state_t            r_state, w_state_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx, w_len;
  logic [NUM_CH-1:0] r_pulse, w_pulse_nx, r_pending, w_pending_nx;
  logic [NUM_CH-1:0] w_edge, w_edge_ok, w_drop;
  logic [AW-1:0]     r_active, w_active_nx, w_grant;
  logic              r_drop, w_drop_nx;
  logic [c_ARM-1:0]  r_arm;
  logic              w_take_rst;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    hps_reset_req_sequencer_edge_sync_detect #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_RISING (EDGE_TYPE_VEC[ch])
    ) u_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_sig  (i_sig_in[ch]),
      .o_edge (w_edge[ch])
    );
  end

  // After rst_n the synchronisers fill from zero; blank edges until prev has caught up
  // so a level that was already high does not look like a fresh request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_arm <= '0;
    else        r_arm <= {r_arm[c_ARM-2:0], 1'b1};
  end

  assign w_edge_ok  = w_edge & {NUM_CH{r_arm[c_ARM-1] & i_sys_rst_n}};
  assign w_drop     = w_edge_ok & (r_pending | r_pulse);
  assign w_take_rst = !i_sys_rst_n && (!IGNORE_RST_WHILE_BUSY || (r_state == ST_IDLE));

  always_comb begin
    w_grant = '0;
    w_len   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_grant = AW'(i);
        w_len   = PULSE_EXT_VEC[(NUM_CH-1-i)*CNT_W +: CNT_W];
      end
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_pulse_nx   = r_pulse;
    w_active_nx  = r_active;
    w_pending_nx = r_pending | (w_edge_ok & ~w_drop);
    w_drop_nx    = (|w_drop) ? 1'b1 : (i_drop_clr ? 1'b0 : r_drop);

    case (r_state)
      ST_IDLE: begin
        if (|r_pending) begin
          w_state_nx   = ST_PULSE;
          w_active_nx  = w_grant;
          w_pulse_nx   = NUM_CH'(1) << w_grant;
          w_pending_nx = w_pending_nx & ~(NUM_CH'(1) << w_grant);
          w_cnt_nx     = CNT_W'(len_to_init(32'(w_len)));
        end
      end
      ST_PULSE: begin
        if (r_cnt == '0) begin
          w_pulse_nx = '0;
          if (HOLDOFF > 0) begin
            w_state_nx = ST_HOLDOFF;
            w_cnt_nx   = c_HOLD_INIT;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (r_cnt == '0) w_state_nx = ST_IDLE;
        else             w_cnt_nx   = r_cnt - CNT_W'(1);
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_pulse_nx = '0;
        w_cnt_nx   = '0;
      end
    endcase

    if (!i_sys_rst_n) w_pending_nx = '0;
    if (w_take_rst) begin
      w_state_nx  = ST_IDLE;
      w_pulse_nx  = '0;
      w_cnt_nx    = '0;
      w_active_nx = r_active;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pulse   <= '0;
      r_active  <= '0;
      r_pending <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_pulse   <= w_pulse_nx;
      r_active  <= w_active_nx;
      r_pending <= w_pending_nx;
      r_drop    <= w_drop_nx;
    end
  end

  assign o_pulse_out   = r_pulse;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_active_ch   = r_active;
  assign o_pending     = r_pending;
  assign o_drop_sticky = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_hps_reset_req_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hps_reset_req_sequencer                                     |
// | Brief    : Directed self-checking bench for hps_reset_req_sequencer      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_hps_reset_req_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, sys_rst_n, drop_clr;
  logic [2:0] sig;

  logic [2:0] pulse_a, pend_a, pulse_b, pend_b, pulse_c, pend_c;
  logic [1:0] act_a, act_b, act_c;
  logic       busy_a, busy_b, busy_c, drop_a, drop_b, drop_c;

  int n_total = 0;
  int n_bad   = 0;
  int n_multi = 0;

  always #5 clk = ~clk;

  hps_reset_req_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .i_sys_rst_n(sys_rst_n), .i_sig_in(sig), .i_drop_clr(drop_clr),
    .o_pulse_out(pulse_a), .o_busy(busy_a), .o_active_ch(act_a), .o_pending(pend_a), .o_drop_sticky(drop_a)
  );

  hps_reset_req_sequencer #(.IGNORE_RST_WHILE_BUSY(1'b0)) u_dut_ni (
    .clk(clk), .rst_n(rst_n), .i_sys_rst_n(sys_rst_n), .i_sig_in(sig), .i_drop_clr(drop_clr),
    .o_pulse_out(pulse_b), .o_busy(busy_b), .o_active_ch(act_b), .o_pending(pend_b), .o_drop_sticky(drop_b)
  );

  hps_reset_req_sequencer #(
    .PULSE_EXT_VEC({8'd0, 8'd1, 8'd0}), .EDGE_TYPE_VEC(3'b000), .HOLDOFF(0)
  ) u_dut_f (
    .clk(clk), .rst_n(rst_n), .i_sys_rst_n(sys_rst_n), .i_sig_in(sig), .i_drop_clr(drop_clr),
    .o_pulse_out(pulse_c), .o_busy(busy_c), .o_active_ch(act_c), .o_pending(pend_c), .o_drop_sticky(drop_c)
  );

  always @(negedge clk)
    if (rst_n && (!$onehot0(pulse_a) || !$onehot0(pulse_b) || !$onehot0(pulse_c))) n_multi++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] pulse_of(input int d);
    return (d == 0) ? pulse_a : (d == 1) ? pulse_b : pulse_c;
  endfunction

  function automatic logic [2:0] pend_of(input int d);
    return (d == 0) ? pend_a : (d == 1) ? pend_b : pend_c;
  endfunction

  function automatic logic [1:0] act_of(input int d);
    return (d == 0) ? act_a : (d == 1) ? act_b : act_c;
  endfunction

  // Waits (bounded) for the next pulse of DUT d, then measures its width.
  task automatic wait_pulse(input int d, output logic [2:0] pat, output logic [2:0] pend,
                            output logic [1:0] act, output int lat, output int width);
    lat = 0;
    while (pulse_of(d) == 3'b000 && lat < 200) begin
      tick();
      lat++;
    end
    pat   = pulse_of(d);
    pend  = pend_of(d);
    act   = act_of(d);
    width = 0;
    while (pulse_of(d) != 3'b000 && width < 300) begin
      width++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] pat, pend;
    logic [1:0] act;
    int lat, wid, wa, wb, nz;
    int exp_w[3]      = '{32, 2, 6};
    logic [2:0] exp_p[3] = '{3'b110, 3'b100, 3'b000};

    rst_n = 1'b0; sys_rst_n = 1'b1; sig = 3'b000; drop_clr = 1'b0;
    repeat (3) tick();
    check("rst_pulse", pulse_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_pending", pend_a, 0);
    check("rst_drop", drop_a, 0);
    check("rst_active", act_a, 0);
    rst_n = 1'b1;
    repeat (6) tick();

    // single request on ch1
    sig = 3'b010;
    wait_pulse(0, pat, pend, act, lat, wid);
    check("t1_lat", lat, 4);
    check("t1_pat", pat, 3'b010);
    check("t1_width", wid, 2);
    check("t1_act", act, 1);
    check("t1_busy_ho_first", busy_a, 1);
    repeat (3) tick();
    check("t1_busy_ho_last", busy_a, 1);
    tick();
    check("t1_idle", busy_a, 0);

    // simultaneous requests on all channels
    sig = 3'b000;
    repeat (10) tick();
    sig = 3'b111;
    for (int i = 0; i < 3; i++) begin
      wait_pulse(0, pat, pend, act, lat, wid);
      check($sformatf("t2_lat%0d", i), lat, (i == 0) ? 4 : 5);
      check($sformatf("t2_pat%0d", i), pat, 3'b001 << i);
      check($sformatf("t2_width%0d", i), wid, exp_w[i]);
      check($sformatf("t2_pend%0d", i), pend, exp_p[i]);
      check($sformatf("t2_act%0d", i), act, i);
    end
    repeat (10) tick();

    // retrigger during ch0 pulse, pending-overflow drop, drop_clr
    sig = 3'b000;
    repeat (10) tick();
    sig = 3'b001;
    lat = 0;
    while (pulse_a == 3'b000 && lat < 200) begin tick(); lat++; end
    check("t3_lat", lat, 4);
    wa = 0;
    for (int k = 0; k < 45; k++) begin
      if (k == 2) sig = 3'b000;
      if (k == 7) sig = 3'b011;
      if (k == 11) begin
        check("t3_drop_retrig", drop_a, 1);
        check("t3_pend_ch1", pend_a, 3'b010);
      end
      if (k == 12) drop_clr = 1'b1;
      if (k == 13) drop_clr = 1'b0;
      if (k == 14) begin
        check("t3_drop_cleared", drop_a, 0);
        sig = 3'b001;
      end
      if (k == 18) sig = 3'b011;
      if (k == 25) begin
        check("t3_drop_pending", drop_a, 1);
        check("t3_pend_kept", pend_a, 3'b010);
      end
      if (pulse_a[0]) wa++;
      tick();
    end
    check("t3_ch0_width", wa, 32);
    check("t3_pend_served", pend_a, 0);
    check("t3_active_last", act_a, 1);
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    check("t3_drop_clr", drop_a, 0);

    // sys_rst_n mid-pulse, both IGNORE settings
    sig = 3'b000;
    repeat (10) tick();
    sig = 3'b011;
    lat = 0;
    while (pulse_a == 3'b000 && lat < 200) begin tick(); lat++; end
    check("t4_lat", lat, 4);
    wa = 0; wb = 0;
    for (int k = 0; k < 45; k++) begin
      if (k == 5) sys_rst_n = 1'b0;
      if (k == 6) begin
        check("t4_ni_pulse_off", pulse_b, 0);
        check("t4_pend_a", pend_a, 0);
        check("t4_pend_b", pend_b, 0);
        check("t4_ig_pulse_on", pulse_a, 3'b001);
      end
      if (k == 40) check("t4_ig_idle", busy_a, 0);
      if (pulse_a[0]) wa++;
      if (pulse_b[0]) wb++;
      tick();
    end
    check("t4_ig_width", wa, 32);
    check("t4_ni_width", wb, 6);
    sys_rst_n = 1'b1;
    nz = 0;
    repeat (15) begin tick(); if ((pulse_a | pulse_b) != 3'b000) nz++; end
    check("t4_no_spurious", nz, 0);

    // asynchronous rst_n mid-pulse
    sig = 3'b000;
    repeat (10) tick();
    sig = 3'b100;
    lat = 0;
    while (pulse_a == 3'b000 && lat < 200) begin tick(); lat++; end
    check("t5_lat", lat, 4);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_pulse", pulse_a, 0);
    check("t5_async_busy", busy_a, 0);
    check("t5_async_pend", pend_a, 0);
    tick(); tick();
    rst_n = 1'b1;
    nz = 0;
    repeat (20) begin tick(); if (pulse_a != 3'b000) nz++; end
    check("t5_level_no_pulse", nz, 0);
    check("t5_level_no_pend", pend_a, 0);
    sig = 3'b000;
    repeat (5) tick();
    sig = 3'b100;
    wait_pulse(0, pat, pend, act, lat, wid);
    check("t5_fresh_lat", lat, 4);
    check("t5_fresh_pat", pat, 3'b100);
    check("t5_fresh_width", wid, 6);

    // falling-edge, zero-length field, no holdoff
    repeat (20) tick();
    sig = 3'b111;
    repeat (20) tick();
    sig = 3'b000;
    for (int i = 0; i < 3; i++) begin
      wait_pulse(2, pat, pend, act, lat, wid);
      check($sformatf("t6_lat%0d", i), lat, (i == 0) ? 4 : 1);
      check($sformatf("t6_pat%0d", i), pat, 3'b001 << i);
      check($sformatf("t6_width%0d", i), wid, 1);
      check($sformatf("t6_pend%0d", i), pend, exp_p[i]);
    end

    check("never_two_hot", n_multi, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
